crm_cr: RTL and testbench
=========================

Name: crm_cr

Overview:
- Control RAM (CRAM) plus microinstruction register (CR), sitting at the far end of the CRADR interface.
- Takes the next-address CRADR produced by the microsequencer and latches the addressed 84-bit microword into CR. The CR fields (J, AD, DISP, SKIP, ...) feed back into the sequencer and the datapath.
- Includes the diagnostic loader, which writes a microword in 12-bit chunks, and a diagnostic CR readback path.

Parameters:
- ADDR_W, 11, CRAM address bits (2048 words).
- WORD_W, 84, microword width; bit 83 is the odd-parity bit.
- CHUNK_W, 12, diagnostic load/readback chunk width. WORD_W/CHUNK_W = 7 chunks.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- CRADR  input  12  next microword address from sequencer; bit 11 must be 0.
- crEn  input  1  load CR from CRAM this cycle.
- crClear  input  1  force CR to zero this cycle.
- diagLoadStart  input  1  begin loading one word at diagAddr.
- diagAddr  input  11  CRAM word address for the load.
- diagStrobe  input  1  diagData holds the next chunk.
- diagData  input  12  load chunk, most-significant chunk first.
- diagReadSel  input  3  CR chunk select for readback.
- diagBusy  output  1  loader active.
- diagReadData  output  12  registered readback chunk.
- CR  output  84  microinstruction register.
- J  output  11  CR[10:0], jump field to the sequencer.
- crParityErr  output  1  sticky parity error flag.
- crAddrErr  output  1  sticky out-of-range address flag.

Behaviour:
- Reset drives CR=0, diagReadData=0, diagBusy=0, crParityErr=0, crAddrErr=0, loader state IDLE, chunk counter 0. CRAM contents are not reset.
- CR update, applied at the rising edge in this priority order:
  - reset.
  - crClear: CR <= 0; parity is not checked.
  - crEn with diagBusy=0: CR <= mem[CRADR[10:0]]. Latency is 1 cycle: J is valid the cycle after crEn.
  - Otherwise CR holds. crEn is ignored while diagBusy=1.
- CRADR[11]=1 with an accepted crEn: CR <= 0, crAddrErr <= 1, no parity check.
- Parity: on each CRAM load, if the XOR of all 84 loaded bits is 0 (even parity), crParityErr <= 1. The flag is sticky; only reset clears it. crAddrErr is likewise sticky.
- Loader FSM has three states:
  - IDLE: diagLoadStart -> LOAD; latch diagAddr; clear the assembly register; chunk=0.
  - LOAD: each diagStrobe writes diagData into assembly bits [83-12*chunk -: 12] and increments chunk. The strobe at chunk=6 -> WRITE.
  - WRITE: a single cycle with mem[addr] <= assembly; then -> IDLE.
- diagBusy=1 in LOAD and WRITE. Write data is accepted exactly as presented; the loader does not generate parity.
- diagLoadStart in LOAD or WRITE restarts: the new address is latched, chunk=0, the partial word is discarded, and a pending WRITE is cancelled. Start has priority over a strobe in the same cycle.
- diagStrobe in IDLE is ignored.
- Reset mid-load returns to IDLE with no CRAM write.
- Readback: every cycle diagReadData <= CR chunk diagReadSel, where chunk 0 = CR[83:72] and chunk 6 = CR[11:0]. diagReadSel=7 gives 0. Latency is 1 cycle.
- Same-cycle CRAM write and CR read of the same address cannot occur, because crEn is ignored while busy.

Test Plan:
- Load 0x8_0000_0000_0000_0000_0000_0123 at address 0x010 via start + 7 strobes. Expected: busy for 8 cycles. Then CRADR=0x010 + crEn gives CR equal to that word next cycle, J=0x123, crParityErr=0 (odd parity).
- Load an all-zero word at 0x020, then crEn at 0x020. Expected: CR=0, crParityErr=1. A subsequent good read leaves the flag at 1; reset clears it.
- crEn with CRADR=0x800. Expected: CR=0, crAddrErr=1. crClear together with crEn gives CR=0 and no flag change.
- Start load at 0x030, 3 strobes, then start at 0x031 and 7 strobes. Expected: only 0x031 is written; 0x030 is unchanged. Repeat with reset after 6 strobes: no write, busy=0.
- With CR loaded, step diagReadSel 0..7. Expected: diagReadData follows one cycle later with CR[83:72] ... CR[11:0], then 0.
- Hold crEn=1 during a load. Expected: CR holds its value throughout busy and resumes loading from CRADR the cycle after busy drops.

Source files
------------

// File: rtl/crm_cr.sv
// Control RAM with microinstruction register (CR), diagnostic chunk loader
// and registered CR chunk readback.
module crm_cr #(
   parameter int ADDR_W  = 11,
   parameter int WORD_W  = 84,
   parameter int CHUNK_W = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_W:0]      CRADR,
   input  logic                 crEn,
   input  logic                 crClear,
   input  logic                 diagLoadStart,
   input  logic [ADDR_W-1:0]    diagAddr,
   input  logic                 diagStrobe,
   input  logic [CHUNK_W-1:0]   diagData,
   input  logic [2:0]           diagReadSel,
   output logic                 diagBusy,
   output logic [CHUNK_W-1:0]   diagReadData,
   output logic [WORD_W-1:0]    CR,
   output logic [ADDR_W-1:0]    J,
   output logic                 crParityErr,
   output logic                 crAddrErr
);

   localparam int NCHUNK = WORD_W / CHUNK_W;
   localparam logic [2:0] LAST_CHUNK = 3'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic                mem_we;
   logic [2:0]          chunk;
   logic [ADDR_W-1:0]   load_addr;
   logic [WORD_W-1:0]   asm_word;
   logic [WORD_W-1:0]   rd_word;
   logic [WORD_W-1:0]   mem [2**ADDR_W];

   // Loader protocol: diagLoadStart is a one-cycle pulse that (re)starts a
   // load; each cycle with diagStrobe=1 in LOAD consumes exactly one chunk.
   // There is no back-pressure: diagBusy only tells software a load is open.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      case (state)
         S_IDLE: begin
            if (diagLoadStart) state_next = S_LOAD;
         end
         S_LOAD: begin
            if (diagLoadStart)
               state_next = S_LOAD;
            else if (diagStrobe && chunk == LAST_CHUNK)
               state_next = S_WRITE;
         end
         S_WRITE: begin
            if (diagLoadStart) begin
               state_next = S_LOAD;
            end else begin
               state_next = S_IDLE;
               mem_we     = ~reset;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         chunk     <= 3'd0;
         load_addr <= '0;
         asm_word  <= '0;
      end else begin
         state <= state_next;
         if (diagLoadStart) begin
            load_addr <= diagAddr;
            asm_word  <= '0;
            chunk     <= 3'd0;
         end else if (state == S_LOAD && diagStrobe) begin
            asm_word[WORD_W-1-CHUNK_W*32'(chunk) -: CHUNK_W] <= diagData;
            chunk <= chunk + 3'd1;
         end
      end
   end

   // CRAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[load_addr] <= asm_word;
   end

   assign diagBusy = (state != S_IDLE);
   assign rd_word  = mem[CRADR[ADDR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         CR          <= '0;
         crParityErr <= 1'b0;
         crAddrErr   <= 1'b0;
      end else if (crClear) begin
         CR <= '0;
      end else if (crEn && !diagBusy) begin
         if (CRADR[ADDR_W]) begin
            CR        <= '0;
            crAddrErr <= 1'b1;
         end else begin
            CR <= rd_word;
            // Microwords carry odd parity; an even word flags an error.
            if (~^rd_word) crParityErr <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         diagReadData <= '0;
      else if (32'(diagReadSel) < NCHUNK)
         diagReadData <= CR[WORD_W-1-CHUNK_W*32'(diagReadSel) -: CHUNK_W];
      else
         diagReadData <= '0;
   end

   assign J = CR[ADDR_W-1:0];

endmodule

// File: tb/tb_crm_cr.sv
// Self-checking bench for crm_cr: diagnostic load, CR fetch, error flags,
// load restart/abort, readback and crEn suppression while busy.
module tb_crm_cr;

   logic          clk = 1'b0;
   logic          reset;
   logic [11:0]   CRADR;
   logic          crEn;
   logic          crClear;
   logic          diagLoadStart;
   logic [10:0]   diagAddr;
   logic          diagStrobe;
   logic [11:0]   diagData;
   logic [2:0]    diagReadSel;
   logic          diagBusy;
   logic [11:0]   diagReadData;
   logic [83:0]   CR;
   logic [10:0]   J;
   logic          crParityErr;
   logic          crAddrErr;

   int errors = 0;
   int checks = 0;

   logic [83:0] exp_q[$];
   logic [83:0] model_mem [int];
   logic [83:0] exp;
   logic [83:0] w1;

   crm_cr dut (
      .clk           (clk),
      .reset         (reset),
      .CRADR         (CRADR),
      .crEn          (crEn),
      .crClear       (crClear),
      .diagLoadStart (diagLoadStart),
      .diagAddr      (diagAddr),
      .diagStrobe    (diagStrobe),
      .diagData      (diagData),
      .diagReadSel   (diagReadSel),
      .diagBusy      (diagBusy),
      .diagReadData  (diagReadData),
      .CR            (CR),
      .J             (J),
      .crParityErr   (crParityErr),
      .crAddrErr     (crAddrErr)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [10:0] a, input logic [83:0] w, output int busy_cnt);
      diagLoadStart = 1'b1;
      diagAddr      = a;
      tick();
      diagLoadStart = 1'b0;
      busy_cnt      = int'(diagBusy);
      for (int k = 0; k < 7; k++) begin
         diagStrobe = 1'b1;
         diagData   = w[83-12*k -: 12];
         tick();
         busy_cnt += int'(diagBusy);
      end
      diagStrobe = 1'b0;
      tick();
      busy_cnt += int'(diagBusy);
      model_mem[int'(a)] = w;
   endtask

   task automatic cr_read(input logic [11:0] a);
      crEn  = 1'b1;
      CRADR = a;
      if (a[11]) exp_q.push_back('0);
      else       exp_q.push_back(model_mem[int'(a[10:0])]);
      tick();
      crEn = 1'b0;
   endtask

   task automatic pop_exp();
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got size 0 required >0");
         exp = 'x;
      end else begin
         exp = exp_q.pop_front();
      end
   endtask

   function automatic logic [83:0] rand_word(input bit odd);
      logic [83:0] w;
      w = {$urandom(), $urandom(), $urandom()};
      if ((^w) != odd) w[0] = ~w[0];
      return w;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; CRADR = '0; crEn = 0; crClear = 0; diagLoadStart = 0;
      diagAddr = '0; diagStrobe = 0; diagData = '0; diagReadSel = '0;
      tick(); tick();
      checks++;
      if (CR !== 84'd0 || J !== 11'd0) begin
         errors++; $display("FAIL reset_cr: got CR=%h J=%h required 0", CR, J);
      end
      checks++;
      if (diagBusy !== 1'b0 || diagReadData !== 12'd0) begin
         errors++; $display("FAIL reset_diag: got busy=%b rd=%h required 0/000", diagBusy, diagReadData);
      end
      checks++;
      if (crParityErr !== 1'b0 || crAddrErr !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got par=%b addr=%b required 0/0", crParityErr, crAddrErr);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_load_fetch();
      int bc;
      load_word(11'h010, w1, bc);
      checks++;
      if (bc != 8) begin
         errors++; $display("FAIL load_busy_cycles: got %0d required 8", bc);
      end
      cr_read(12'h010);
      pop_exp();
      checks++;
      if (CR !== exp) begin
         errors++; $display("FAIL fetch_cr: got %h required %h", CR, exp);
      end
      checks++;
      if (J !== 11'h123) begin
         errors++; $display("FAIL fetch_j: got %h required 123", J);
      end
      checks++;
      if (crParityErr !== 1'b0) begin
         errors++; $display("FAIL fetch_parity: got %b required 0", crParityErr);
      end
   endtask

   task automatic test_parity();
      int bc;
      load_word(11'h020, 84'd0, bc);
      cr_read(12'h020);
      pop_exp();
      checks++;
      if (CR !== exp || crParityErr !== 1'b1) begin
         errors++; $display("FAIL parity_bad_word: got CR=%h par=%b required %h/1", CR, crParityErr, exp);
      end
      cr_read(12'h010);
      pop_exp();
      checks++;
      if (CR !== exp || crParityErr !== 1'b1) begin
         errors++; $display("FAIL parity_sticky: got CR=%h par=%b required %h/1", CR, crParityErr, exp);
      end
      reset = 1'b1; tick(); reset = 1'b0;
      checks++;
      if (crParityErr !== 1'b0) begin
         errors++; $display("FAIL parity_reset_clear: got %b required 0", crParityErr);
      end
   endtask

   task automatic test_addr_err();
      cr_read(12'h010);
      pop_exp();
      cr_read(12'h800);
      pop_exp();
      checks++;
      if (CR !== exp || crAddrErr !== 1'b1) begin
         errors++; $display("FAIL addr_err_set: got CR=%h addr=%b required %h/1", CR, crAddrErr, exp);
      end
      reset = 1'b1; tick(); reset = 1'b0;
      cr_read(12'h010);
      pop_exp();
      crClear = 1'b1; crEn = 1'b1; CRADR = 12'h800;
      tick();
      checks++;
      if (CR !== 84'd0 || crAddrErr !== 1'b0) begin
         errors++; $display("FAIL clear_beats_addr: got CR=%h addr=%b required 0/0", CR, crAddrErr);
      end
      CRADR = 12'h020;
      tick();
      crClear = 1'b0; crEn = 1'b0;
      checks++;
      if (CR !== 84'd0 || crParityErr !== 1'b0) begin
         errors++; $display("FAIL clear_no_parity: got CR=%h par=%b required 0/0", CR, crParityErr);
      end
   endtask

   task automatic test_restart();
      int bc;
      logic [83:0] wa, wb, wc, wd, we;
      wa = rand_word(1); wb = rand_word(1); wc = rand_word(1);
      wd = rand_word(1); we = rand_word(1);
      load_word(11'h030, wa, bc);
      diagLoadStart = 1'b1; diagAddr = 11'h030; tick(); diagLoadStart = 1'b0;
      for (int k = 0; k < 3; k++) begin
         diagStrobe = 1'b1; diagData = wb[83-12*k -: 12]; tick();
      end
      // restart with a simultaneous strobe: start must win
      diagLoadStart = 1'b1; diagAddr = 11'h031; diagData = 12'hfff; tick();
      diagLoadStart = 1'b0;
      for (int k = 0; k < 7; k++) begin
         diagStrobe = 1'b1; diagData = wc[83-12*k -: 12]; tick();
      end
      diagStrobe = 1'b0; tick();
      model_mem[32'h031] = wc;
      checks++;
      if (diagBusy !== 1'b0) begin
         errors++; $display("FAIL restart_busy_end: got %b required 0", diagBusy);
      end
      cr_read(12'h030);
      pop_exp();
      checks++;
      if (CR !== exp) begin
         errors++; $display("FAIL restart_old_addr: got %h required %h", CR, exp);
      end
      cr_read(12'h031);
      pop_exp();
      checks++;
      if (CR !== exp) begin
         errors++; $display("FAIL restart_new_addr: got %h required %h", CR, exp);
      end
      load_word(11'h032, wd, bc);
      diagLoadStart = 1'b1; diagAddr = 11'h032; tick(); diagLoadStart = 1'b0;
      for (int k = 0; k < 6; k++) begin
         diagStrobe = 1'b1; diagData = we[83-12*k -: 12]; tick();
      end
      diagStrobe = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
      checks++;
      if (diagBusy !== 1'b0) begin
         errors++; $display("FAIL abort_busy: got %b required 0", diagBusy);
      end
      diagStrobe = 1'b1; diagData = we[11:0]; tick(); diagStrobe = 1'b0; tick();
      checks++;
      if (diagBusy !== 1'b0) begin
         errors++; $display("FAIL idle_strobe_ignored: got busy=%b required 0", diagBusy);
      end
      cr_read(12'h032);
      pop_exp();
      checks++;
      if (CR !== exp) begin
         errors++; $display("FAIL abort_no_write: got %h required %h", CR, exp);
      end
   endtask

   task automatic test_readback();
      logic [83:0] rb;
      logic [11:0] got;
      cr_read(12'h010);
      pop_exp();
      rb = exp;
      for (int s = 0; s < 8; s++) begin
         diagReadSel = 3'(s);
         if (s == 7) exp_q.push_back('0);
         else        exp_q.push_back({72'd0, rb[83-12*s -: 12]});
         tick();
         pop_exp();
         got = diagReadData;
         checks++;
         if (got !== exp[11:0]) begin
            errors++; $display("FAIL readback_sel%0d: got %h required %h", s, got, exp[11:0]);
         end
      end
      diagReadSel = 3'd0;
   endtask

   task automatic test_busy_hold();
      logic [83:0] wn;
      wn = rand_word(1);
      crEn = 1'b1; CRADR = 12'h010;
      diagLoadStart = 1'b1; diagAddr = 11'h040;
      exp_q.push_back(model_mem[32'h010]);
      tick();
      diagLoadStart = 1'b0;
      CRADR = 12'h031;
      pop_exp();
      for (int k = 0; k < 7; k++) begin
         diagStrobe = 1'b1; diagData = wn[83-12*k -: 12]; tick();
         checks++;
         if (CR !== exp) begin
            errors++; $display("FAIL hold_during_busy%0d: got %h required %h", k, CR, exp);
         end
      end
      diagStrobe = 1'b0;
      tick();
      checks++;
      if (CR !== exp || diagBusy !== 1'b0) begin
         errors++; $display("FAIL hold_write_cycle: got CR=%h busy=%b required %h/0", CR, diagBusy, exp);
      end
      model_mem[32'h040] = wn;
      exp_q.push_back(model_mem[32'h031]);
      tick();
      crEn = 1'b0;
      pop_exp();
      checks++;
      if (CR !== exp) begin
         errors++; $display("FAIL resume_after_busy: got %h required %h", CR, exp);
      end
      cr_read(12'h040);
      pop_exp();
      checks++;
      if (CR !== exp) begin
         errors++; $display("FAIL hold_load_written: got %h required %h", CR, exp);
      end
   endtask

   task automatic test_random_words();
      int bc;
      logic exp_par;
      logic [83:0] w;
      reset = 1'b1; tick(); reset = 1'b0;
      exp_par = 1'b0;
      for (int i = 0; i < 6; i++) begin
         w = rand_word(i != 3);
         load_word(11'(32'h100 + $urandom_range(0, 255) * 4 + i % 4), w, bc);
         cr_read({1'b0, diagAddr});
         exp_par = exp_par | ~^w;
         pop_exp();
         checks++;
         if (CR !== exp || J !== w[10:0] || crParityErr !== exp_par) begin
            errors++;
            $display("FAIL random_fetch%0d: got CR=%h par=%b required %h/%b", i, CR, crParityErr, exp, exp_par);
         end
      end
   endtask

   initial begin
      w1 = {1'b1, 71'd0, 12'h123};
      test_reset();
      test_load_fetch();
      test_parity();
      test_addr_err();
      test_restart();
      test_readback();
      test_busy_hold();
      test_random_words();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
